// File: rtl/sdram_host_arbiter_pkg.sv
// Shared types and helpers for the SDRAM host-port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int DEF_TIMEOUT = 1024;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sdram_host_arbiter_if.sv
// Requester-side and controller-side Wishbone signals of the host-port arbiter.
interface sdram_host_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 26
);
  logic [NREQ-1:0]          req_cyc_i;
  logic [NREQ-1:0]          req_stb_i;
  logic [NREQ-1:0]          req_we_i;
  logic [NREQ*AW-1:0]       req_adr_i;
  logic [NREQ*DW-1:0]       req_dat_i;
  logic [NREQ*(DW/8)-1:0]   req_sel_i;
  logic [NREQ-1:0]          req_ack_o;
  logic [NREQ-1:0]          req_err_o;
  logic [DW-1:0]            req_dat_o;
  logic                     mc_cyc_o;
  logic                     mc_stb_o;
  logic                     mc_we_o;
  logic [AW-1:0]            mc_adr_o;
  logic [DW-1:0]            mc_dat_o;
  logic [DW/8-1:0]          mc_sel_o;
  logic                     mc_ack_i;
  logic [DW-1:0]            mc_dat_i;
  logic [NREQ-1:0]          grant_o;
  logic                     busy_o;

  modport slave (
    input  req_cyc_i, req_stb_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, mc_ack_i, mc_dat_i,
    output req_ack_o, req_err_o, req_dat_o, mc_cyc_o, mc_stb_o, mc_we_o, mc_adr_o, mc_dat_o,
           mc_sel_o, grant_o, busy_o
  );

  modport master (
    output req_cyc_i, req_stb_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, mc_ack_i, mc_dat_i,
    input  req_ack_o, req_err_o, req_dat_o, mc_cyc_o, mc_stb_o, mc_we_o, mc_adr_o, mc_dat_o,
           mc_sel_o, grant_o, busy_o
  );
endinterface

// File: rtl/sdram_host_arbiter_picker.sv
// Combinational rotating-priority encoder: first requester after the last winner wins.
module sdram_rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] win_o,
  output logic            valid_o
);
  int            sum_s;
  logic [IW-1:0] idx_s;
  logic          found_s;

  // Scan forward from the slot after the last winner, wrapping at NREQ
  always_comb begin
    win_o   = '0;
    found_s = 1'b0;
    sum_s   = 0;
    idx_s   = '0;
    valid_o = |req_i;
    for (int i = 1; i <= NREQ; i++) begin
      sum_s          = (int'(last_i) + i >= NREQ) ? int'(last_i) + i - NREQ : int'(last_i) + i;
      idx_s          = IW'(sum_s);
      win_o[idx_s]   = win_o[idx_s] | (req_i[idx_s] & ~found_s);
      found_s        = found_s | req_i[idx_s];
    end
  end
endmodule

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing the controller's Wishbone host port among NREQ requesters,
// with grants locked for a whole cycle and a watchdog that aborts ack-less cycles.
module sdram_host_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int dw      = 32,
  parameter int APP_AW  = 26,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  sdram_host_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = dw / 8;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] win_s;
  logic [IW-1:0]   owner_s;
  logic            valid_s, abort_s, own_cyc_s, own_stb_s;

  // Aborted requesters stay out of arbitration until they drop cyc
  sdram_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req_i   (bus.req_cyc_i & ~mask_q),
    .last_i  (last_q),
    .win_o   (win_s),
    .valid_o (valid_s)
  );

  assign owner_s     = IW'(onehot2idx(8'(grant_q)));
  assign bus.grant_o = grant_q;
  assign bus.busy_o  = (state_q == GRANT);

  // Owner mux toward the controller; ack/err routed back to the owner only
  always_comb begin
    own_cyc_s     = bus.req_cyc_i[owner_s];
    own_stb_s     = bus.req_stb_i[owner_s];
    abort_s       = (state_q == GRANT) && (cnt_q == CW'(TIMEOUT));
    bus.mc_cyc_o  = 1'b0;
    bus.mc_stb_o  = 1'b0;
    bus.mc_we_o   = 1'b0;
    bus.mc_adr_o  = '0;
    bus.mc_dat_o  = '0;
    bus.mc_sel_o  = '0;
    bus.req_ack_o = '0;
    bus.req_err_o = '0;
    if ((state_q == GRANT) && !abort_s) begin
      bus.mc_cyc_o  = own_cyc_s;
      bus.mc_stb_o  = own_stb_s;
      bus.mc_we_o   = bus.req_we_i[owner_s];
      bus.mc_adr_o  = bus.req_adr_i[owner_s*APP_AW +: APP_AW];
      bus.mc_dat_o  = bus.req_dat_i[owner_s*dw +: dw];
      bus.mc_sel_o  = bus.req_sel_i[owner_s*SW +: SW];
      bus.req_ack_o = grant_q & {NREQ{bus.mc_ack_i}};
    end else if (abort_s) begin
      bus.req_err_o = grant_q;
    end else begin
      bus.req_ack_o = '0;
    end
    bus.req_dat_o = (state_q == GRANT) ? bus.mc_dat_i : '0;
  end

  // Next state, grant, mask and watchdog
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    mask_d  = mask_q & bus.req_cyc_i;
    case (state_q)
      IDLE: begin
        if (valid_s) begin
          state_d = GRANT;
          grant_d = win_s;
          last_d  = IW'(onehot2idx(8'(win_s)));
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (abort_s) begin
          mask_d  = mask_d | grant_q;
          grant_d = '0;
          state_d = RELEASE;
        end else if (!own_cyc_s) begin
          grant_d = '0;
          state_d = RELEASE;
        end else if (own_stb_s && !bus.mc_ack_i) begin
          cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
